// File: rtl/hsv_axi_mem_responder.sv
// AXI4 subordinate backed by a word-organised on-chip RAM.
// Independent read and write channel FSMs with per-beat OKAY/SLVERR/DECERR responses.
module hsv_axi_mem_responder #(
    parameter int unsigned DepthWords = 1024,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp
);

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10,
        AXI_BURST_RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [2:0] {
        AXI_SIZE_1   = 3'd0,
        AXI_SIZE_2   = 3'd1,
        AXI_SIZE_4   = 3'd2,
        AXI_SIZE_8   = 3'd3,
        AXI_SIZE_16  = 3'd4,
        AXI_SIZE_32  = 3'd5,
        AXI_SIZE_64  = 3'd6,
        AXI_SIZE_128 = 3'd7
    } axi_size_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    localparam int unsigned IdxW     = (DepthWords > 1) ? $clog2(DepthWords) : 1;
    localparam logic [31:0] MemBytes = 32'(DepthWords * 4);

    logic [31:0] mem [DepthWords];

    function automatic axi_resp_t beat_resp(input logic [31:0] addr, input axi_size_t size,
                                            input axi_burst_t burst);
        if (burst == AXI_BURST_WRAP || burst == AXI_BURST_RSVD || size > AXI_SIZE_4)
            return AXI_RESP_SLVERR;
        else if ((addr - BaseAddr) >= MemBytes)
            return AXI_RESP_DECERR;
        else
            return AXI_RESP_OKAY;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input axi_size_t size,
                                              input axi_burst_t burst);
        if (burst == AXI_BURST_FIXED)
            return addr;
        else
            return addr + (32'd1 << size);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
        return IdxW'((addr - BaseAddr) >> 2);
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state_q, r_state_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    axi_resp_t   rresp_q, rresp_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    axi_size_t   r_size_q, r_size_d;
    axi_burst_t  r_burst_q, r_burst_d;
    logic [7:0]  r_beat_q, r_beat_d;

    logic        ar_hs, r_hs;
    axi_resp_t   ar_resp, r_next_resp;
    logic [31:0] r_next_addr;

    assign ar_hs       = axi_arvalid && arready_q;
    assign r_hs        = rvalid_q && axi_rready;
    assign ar_resp     = beat_resp(axi_araddr, axi_size_t'(axi_arsize), axi_burst_t'(axi_arburst));
    assign r_next_addr = next_addr(r_addr_q, r_size_q, r_burst_q);
    assign r_next_resp = beat_resp(r_next_addr, r_size_q, r_burst_q);

    // Read next-state; arready lags R_IDLE by a cycle, giving the idle gap after a burst
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    r_addr_d  = axi_araddr;
                    r_len_d   = axi_arlen;
                    r_size_d  = axi_size_t'(axi_arsize);
                    r_burst_d = axi_burst_t'(axi_arburst);
                    r_beat_d  = 8'd0;
                    rlast_d   = (axi_arlen == 8'd0);
                    rresp_d   = ar_resp;
                    rdata_d   = (ar_resp == AXI_RESP_OKAY) ? mem[word_idx(axi_araddr)] : 32'd0;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        r_addr_d = r_next_addr;
                        r_beat_d = r_beat_q + 8'd1;
                        rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                        rresp_d  = r_next_resp;
                        rdata_d  = (r_next_resp == AXI_RESP_OKAY) ? mem[word_idx(r_next_addr)]
                                                                  : 32'd0;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= AXI_RESP_OKAY;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_size_q  <= AXI_SIZE_4;
            r_burst_q <= AXI_BURST_INCR;
            r_beat_q  <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state_q, w_state_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    axi_resp_t   bresp_q, bresp_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    axi_size_t   w_size_q, w_size_d;
    axi_burst_t  w_burst_q, w_burst_d;
    logic [8:0]  w_beat_q, w_beat_d;
    logic        w_slv_q, w_slv_d;
    logic        w_dec_q, w_dec_d;

    logic            aw_hs, w_hs, b_hs;
    axi_resp_t       w_resp;
    logic            w_in_len, w_early_last;
    logic            mem_we;
    logic [IdxW-1:0] mem_widx;

    assign aw_hs        = axi_awvalid && awready_q;
    assign w_hs         = axi_wvalid && wready_q;
    assign b_hs         = bvalid_q && axi_bready;
    assign w_resp       = beat_resp(w_addr_q, w_size_q, w_burst_q);
    assign w_in_len     = (w_beat_q <= {1'b0, w_len_q});
    assign w_early_last = axi_wlast && (w_beat_q < {1'b0, w_len_q});

    // Write next-state, error accumulation and RAM write enable
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_slv_d   = w_slv_q;
        w_dec_d   = w_dec_q;
        mem_we    = 1'b0;
        mem_widx  = word_idx(w_addr_q);
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_state_d = W_DATA;
                    wready_d  = 1'b1;
                    w_addr_d  = axi_awaddr;
                    w_len_d   = axi_awlen;
                    w_size_d  = axi_size_t'(axi_awsize);
                    w_burst_d = axi_burst_t'(axi_awburst);
                    w_beat_d  = 9'd0;
                    w_slv_d   = 1'b0;
                    w_dec_d   = 1'b0;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                wready_d = 1'b1;
                if (w_hs) begin
                    mem_we   = (w_resp == AXI_RESP_OKAY) && w_in_len;
                    w_slv_d  = w_slv_q || (w_resp == AXI_RESP_SLVERR) || !w_in_len || w_early_last;
                    w_dec_d  = w_dec_q || (w_resp == AXI_RESP_DECERR);
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_beat_d = (w_beat_q == 9'h1FF) ? w_beat_q : w_beat_q + 9'd1;
                    if (axi_wlast) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_slv_d ? AXI_RESP_SLVERR
                                  : (w_dec_d ? AXI_RESP_DECERR : AXI_RESP_OKAY);
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_size_q  <= AXI_SIZE_4;
            w_burst_q <= AXI_BURST_INCR;
            w_beat_q  <= 9'd0;
            w_slv_q   <= 1'b0;
            w_dec_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_slv_q   <= w_slv_d;
            w_dec_q   <= w_dec_d;
        end
    end

    // RAM byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clk_core) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (axi_wstrb[i]) mem[mem_widx][8*i +: 8] <= axi_wdata[8*i +: 8];
            end
        end
    end

    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;
    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;

endmodule

// File: tb/tb_hsv_axi_mem_responder.sv
// Directed testbench for hsv_axi_mem_responder: single beats, strobes, stalls,
// end-of-RAM crossing, illegal bursts, length mismatches, concurrency and mid-burst reset.
module tb_hsv_axi_mem_responder;

    logic        clk_core = 1'b0;
    logic        rst_core = 1'b1;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_araddr = 32'd0;
    logic [7:0]  axi_arlen = 8'd0;
    logic [2:0]  axi_arsize = 3'd2;
    logic [1:0]  axi_arburst = 2'b01;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_awaddr = 32'd0;
    logic [7:0]  axi_awlen = 8'd0;
    logic [2:0]  axi_awsize = 3'd2;
    logic [1:0]  axi_awburst = 2'b01;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [31:0] axi_wdata = 32'd0;
    logic [3:0]  axi_wstrb = 4'd0;
    logic        axi_wlast = 1'b0;
    logic        axi_bvalid;
    logic        axi_bready = 1'b0;
    logic [1:0]  axi_bresp;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    always #5 clk_core = ~clk_core;

    hsv_axi_mem_responder #(.DepthWords(1024), .BaseAddr(32'h0000_0000)) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    // All drivers run at posedge+1 so DUT outputs are stable when sampled.
    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int cnt = 0;
        axi_araddr = addr; axi_arlen = len; axi_arsize = 3'd2; axi_arburst = burst;
        axi_arvalid = 1'b1;
        while (!axi_arready && cnt < 50) begin tick(); cnt++; end
        if (!axi_arready) begin
            checks++; failures++;
            $display("FAIL ar_timeout addr=%h arready=%b expected 1", addr, axi_arready);
        end
        tick();
        axi_arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int cnt = 0;
        axi_awaddr = addr; axi_awlen = len; axi_awsize = 3'd2; axi_awburst = burst;
        axi_awvalid = 1'b1;
        while (!axi_awready && cnt < 50) begin tick(); cnt++; end
        if (!axi_awready) begin
            checks++; failures++;
            $display("FAIL aw_timeout addr=%h awready=%b expected 1", addr, axi_awready);
        end
        tick();
        axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int cnt = 0;
        axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
        while (!axi_wready && cnt < 50) begin tick(); cnt++; end
        if (!axi_wready) begin
            checks++; failures++;
            $display("FAIL w_timeout data=%h wready=%b expected 1", data, axi_wready);
        end
        tick();
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp);
        int cnt = 0;
        axi_bready = 1'b1;
        while (!axi_bvalid && cnt < 50) begin tick(); cnt++; end
        if (!axi_bvalid) begin
            checks++; failures++;
            $display("FAIL b_timeout bvalid=%b expected 1", axi_bvalid);
        end
        resp = axi_bresp;
        tick();
        axi_bready = 1'b0;
    endtask

    // Beat i carries base+i; wlast on the final beat sent.
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                               input logic [31:0] base, input int nbeats, output logic [1:0] resp);
        aw_send(addr, len, burst);
        for (int i = 0; i < nbeats; i++) w_send(base + 32'(i), 4'hF, i == nbeats - 1);
        b_recv(resp);
    endtask

    // rready held high; collects up to 4 beats.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              output logic [31:0] d[4], output logic [1:0] r[4], output logic l[4]);
        for (int i = 0; i < 4; i++) begin d[i] = 32'hX; r[i] = 2'bX; l[i] = 1'bX; end
        ar_send(addr, len, burst);
        axi_rready = 1'b1;
        for (int i = 0; i <= int'(len) && i < 4; i++) begin
            int cnt = 0;
            while (!axi_rvalid && cnt < 50) begin tick(); cnt++; end
            if (!axi_rvalid) begin
                checks++; failures++;
                $display("FAIL r_timeout beat=%0d rvalid=%b expected 1", i, axi_rvalid);
                break;
            end
            d[i] = axi_rdata; r[i] = axi_rresp; l[i] = axi_rlast;
            tick();
        end
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst_core = 1'b1;
        repeat (3) tick();
        checks++;
        if ({axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid, axi_rlast} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 000000",
                     {axi_arready, axi_awready, axi_wready, axi_rvalid, axi_bvalid, axi_rlast});
        end
        checks++;
        if ({axi_rdata, axi_rresp, axi_bresp} !== 36'd0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b expected 0", axi_rdata, axi_rresp, axi_bresp);
        end
        rst_core = 1'b0;
        tick();
        checks++;
        if ({axi_arready, axi_awready} !== 2'b11) begin
            failures++;
            $display("FAIL post_reset_ready got %b expected 11", {axi_arready, axi_awready});
        end
    endtask

    task automatic test_single();
        logic [1:0] resp;
        aw_send(32'h10, 8'd0, INCR);
        checks++;
        if (axi_wready !== 1'b1) begin
            failures++; $display("FAIL wready_latency got %b expected 1", axi_wready);
        end
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        checks++;
        if (axi_bvalid !== 1'b1) begin
            failures++; $display("FAIL bvalid_latency got %b expected 1", axi_bvalid);
        end
        b_recv(resp);
        checks++;
        if (resp !== OKAY) begin failures++; $display("FAIL single_bresp got %b expected 00", resp); end
        ar_send(32'h10, 8'd0, INCR);
        checks++;
        if ({axi_rvalid, axi_rlast, axi_rresp, axi_rdata} !== {1'b1, 1'b1, OKAY, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL single_read got v=%b l=%b r=%b d=%h expected v=1 l=1 r=00 d=deadbeef",
                     axi_rvalid, axi_rlast, axi_rresp, axi_rdata);
        end
        axi_rready = 1'b1;
        tick();
        axi_rready = 1'b0;
        checks++;
        if (axi_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_drop got %b expected 0", axi_rvalid); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        logic [31:0] d[4]; logic [1:0] r[4]; logic l[4];
        write_burst(32'h20, 8'd0, INCR, 32'h11223344, 1, resp);
        aw_send(32'h20, 8'd0, INCR);
        w_send(32'hAABBCCDD, 4'b0101, 1'b1);
        b_recv(resp);
        read_burst(32'h20, 8'd0, INCR, d, r, l);
        checks++;
        if (d[0] !== 32'h11BB33DD) begin failures++; $display("FAIL strobe_merge got %h expected 11bb33dd", d[0]); end
    endtask

    task automatic test_incr_stall();
        logic [1:0] resp;
        logic [31:0] held;
        write_burst(32'h0, 8'd3, INCR, 32'd1, 4, resp);
        checks++;
        if (resp !== OKAY) begin failures++; $display("FAIL incr_write_bresp got %b expected 00", resp); end
        ar_send(32'h0, 8'd3, INCR);
        for (int i = 0; i < 4; i++) begin
            axi_rready = 1'b0;
            held = axi_rdata;
            tick();
            checks++;
            if (axi_rvalid !== 1'b1 || axi_rdata !== held) begin
                failures++;
                $display("FAIL stall_hold beat=%0d got v=%b d=%h expected v=1 d=%h", i, axi_rvalid, axi_rdata, held);
            end
            checks++;
            if ({axi_rdata, axi_rlast, axi_rresp} !== {32'(i + 1), i == 3, OKAY}) begin
                failures++;
                $display("FAIL incr_beat beat=%0d got d=%h l=%b r=%b expected d=%h l=%b r=00",
                         i, axi_rdata, axi_rlast, axi_rresp, 32'(i + 1), i == 3);
            end
            axi_rready = 1'b1;
            tick();
        end
        axi_rready = 1'b0;
        checks++;
        if (axi_rvalid !== 1'b0) begin failures++; $display("FAIL incr_end_rvalid got %b expected 0", axi_rvalid); end
    endtask

    task automatic test_end_cross();
        logic [1:0] resp;
        logic [31:0] d[4]; logic [1:0] r[4]; logic l[4];
        write_burst(32'hFFC, 8'd1, INCR, 32'hCAFE0000, 2, resp);
        checks++;
        if (resp !== DECERR) begin failures++; $display("FAIL cross_bresp got %b expected 11", resp); end
        read_burst(32'hFFC, 8'd1, INCR, d, r, l);
        checks++;
        if ({d[0], r[0], l[0]} !== {32'hCAFE0000, OKAY, 1'b0}) begin
            failures++;
            $display("FAIL cross_beat0 got d=%h r=%b l=%b expected d=cafe0000 r=00 l=0", d[0], r[0], l[0]);
        end
        checks++;
        if ({d[1], r[1], l[1]} !== {32'h0, DECERR, 1'b1}) begin
            failures++;
            $display("FAIL cross_beat1 got d=%h r=%b l=%b expected d=0 r=11 l=1", d[1], r[1], l[1]);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] resp;
        logic [31:0] d[4]; logic [1:0] r[4]; logic l[4];
        write_burst(32'h40, 8'd0, INCR, 32'h55, 1, resp);
        write_burst(32'h40, 8'd3, WRAP, 32'h90000000, 4, resp);
        checks++;
        if (resp !== SLVERR) begin failures++; $display("FAIL wrap_bresp got %b expected 10", resp); end
        read_burst(32'h40, 8'd0, INCR, d, r, l);
        checks++;
        if (d[0] !== 32'h55) begin failures++; $display("FAIL wrap_no_write got %h expected 00000055", d[0]); end
        write_burst(32'h50, 8'd3, INCR, 32'h70000000, 3, resp);
        checks++;
        if (resp !== SLVERR) begin failures++; $display("FAIL early_wlast_bresp got %b expected 10", resp); end
        read_burst(32'h58, 8'd0, INCR, d, r, l);
        checks++;
        if (d[0] !== 32'h70000002) begin failures++; $display("FAIL early_wlast_data got %h expected 70000002", d[0]); end
        write_burst(32'h68, 8'd0, INCR, 32'h66, 1, resp);
        write_burst(32'h60, 8'd1, INCR, 32'h30000000, 3, resp);
        checks++;
        if (resp !== SLVERR) begin failures++; $display("FAIL overlong_bresp got %b expected 10", resp); end
        read_burst(32'h64, 8'd1, INCR, d, r, l);
        checks++;
        if ({d[0], d[1]} !== {32'h30000001, 32'h66}) begin
            failures++;
            $display("FAIL overlong_data got %h %h expected 30000001 00000066", d[0], d[1]);
        end
        read_burst(32'h64, 8'd1, FIXED, d, r, l);
        checks++;
        if ({d[0], d[1], l[1]} !== {32'h30000001, 32'h30000001, 1'b1}) begin
            failures++;
            $display("FAIL fixed_read got %h %h l=%b expected 30000001 30000001 l=1", d[0], d[1], l[1]);
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] resp;
        logic [31:0] d[4]; logic [1:0] r[4]; logic l[4];
        logic [31:0] d2[4]; logic [1:0] r2[4]; logic l2[4];
        fork
            read_burst(32'h0, 8'd3, INCR, d, r, l);
            write_burst(32'h80, 8'd3, INCR, 32'hA0, 4, resp);
        join
        checks++;
        if ({d[0], d[1], d[2], d[3]} !== {32'd1, 32'd2, 32'd3, 32'd4} || l[3] !== 1'b1) begin
            failures++;
            $display("FAIL concurrent_read got %h %h %h %h l=%b expected 1 2 3 4 l=1", d[0], d[1], d[2], d[3], l[3]);
        end
        checks++;
        if (resp !== OKAY) begin failures++; $display("FAIL concurrent_bresp got %b expected 00", resp); end
        read_burst(32'h8C, 8'd0, INCR, d2, r2, l2);
        checks++;
        if (d2[0] !== 32'hA3) begin failures++; $display("FAIL concurrent_write got %h expected 000000a3", d2[0]); end
    endtask

    task automatic test_reset_mid();
        logic bv_seen = 1'b0;
        logic [31:0] d[4]; logic [1:0] r[4]; logic l[4];
        aw_send(32'h90, 8'd3, INCR);
        w_send(32'hBB, 4'hF, 1'b0);
        rst_core = 1'b1;
        repeat (2) begin tick(); bv_seen |= axi_bvalid; end
        rst_core = 1'b0;
        tick();
        checks++;
        if (axi_awready !== 1'b1) begin failures++; $display("FAIL mid_reset_awready got %b expected 1", axi_awready); end
        repeat (4) begin bv_seen |= axi_bvalid; tick(); end
        checks++;
        if (bv_seen !== 1'b0) begin failures++; $display("FAIL mid_reset_bvalid got %b expected 0", bv_seen); end
        read_burst(32'h90, 8'd0, INCR, d, r, l);
        checks++;
        if (d[0] !== 32'hBB) begin failures++; $display("FAIL mid_reset_kept got %h expected 000000bb", d[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobe();
        test_incr_stall();
        test_end_cross();
        test_illegal();
        test_concurrent();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
